// File: rtl/mutex_system_n.sv
// -----------------------------------------------------------------------------
// mutex_system_n
//
// Hardware model of the Murphi mutual-exclusion protocol for NUM_NODES nodes.
// Each node is in one of four states: Idle, Try, Crit or Exit. All nodes share
// one lock bit x, where 1 means the lock is free. On each cycle an external
// selector can fire at most one guarded rule. The module also provides the
// following observers:
//   - a per-node starvation monitor
//   - fired and blocked indicators for the previous cycle's request
//   - a step counter of fired rules
//   - a sticky mutual-exclusion violation flag
//
// Ports:
//   clock          in   rising-edge clock
//   reset          in   asynchronous active-low reset
//   io_en_valid    in   a rule request is present this cycle
//   io_en_a        in   rule index; node = idx/4, kind = idx%4
//                       (0 Try, 1 Crit, 2 Exit, 3 Idle)
//   io_n_state     out  node k state at bits [2k+1:2k] (I=0, T=1, C=2, E=3)
//   io_x           out  lock bit (1 = free)
//   io_fired       out  the previous cycle's request fired
//   io_blocked     out  the previous cycle's valid request had a false guard
//                       or an out-of-range index
//   io_starve      out  per-node flag: node has waited MAX_WAIT cycles in Try
//   io_mutex_err   out  sticky invariant-violation flag (should never set)
//   io_step_count  out  number of rules fired since reset (wraps)
// -----------------------------------------------------------------------------
module mutex_system_n #(
  parameter int NUM_NODES = 3,
  parameter int SEL_W     = 4,
  parameter int MAX_WAIT  = 7,
  parameter int CNT_W     = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_en_valid,
  input  logic [SEL_W-1:0]       io_en_a,
  output logic [2*NUM_NODES-1:0] io_n_state,
  output logic                   io_x,
  output logic                   io_fired,
  output logic                   io_blocked,
  output logic [NUM_NODES-1:0]   io_starve,
  output logic                   io_mutex_err,
  output logic [CNT_W-1:0]       io_step_count
);

  typedef enum logic [1:0] {
    ST_I = 2'd0,
    ST_T = 2'd1,
    ST_C = 2'd2,
    ST_E = 2'd3
  } node_state_e;

  localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

  // Shared state
  logic             x_q, x_d;
  logic             fired_q, fired_d;
  logic             blocked_q, blocked_d;
  logic             mutex_err_q, mutex_err_d;
  logic [CNT_W-1:0] step_q, step_d;

  // Request decode
  logic [SEL_W-1:0] node_idx;
  logic [1:0]       kind;
  logic             in_range;

  assign node_idx = io_en_a >> 2;
  assign kind     = io_en_a[1:0];
  // Widen by one bit so that 4*NUM_NODES == 2^SEL_W does not truncate to zero.
  assign in_range = {1'b0, io_en_a} < (SEL_W + 1)'(4 * NUM_NODES);

  // Per-node results gathered from the generate loop
  logic [NUM_NODES-1:0] fire_vec;
  logic [NUM_NODES-1:0] take_vec;
  logic [NUM_NODES-1:0] free_vec;
  logic [NUM_NODES-1:0] crit_next_vec;
  logic [NUM_NODES-1:0] starve_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_NODES; gi++) begin : g_node
      node_state_e st_q, st_d;
      logic [7:0]  wait_q, wait_d;
      logic        starve_q, starve_d;
      logic        sel, fire, take_lock, free_lock;

      assign sel = io_en_valid && in_range && (node_idx == SEL_W'(gi));

      // Guarded rule evaluation for this node
      always_comb begin
        st_d      = st_q;
        fire      = 1'b0;
        take_lock = 1'b0;
        free_lock = 1'b0;
        if (sel) begin
          case (kind)
            2'd0: if (st_q == ST_I) begin
              st_d = ST_T;
              fire = 1'b1;
            end
            2'd1: if (st_q == ST_T && x_q) begin
              st_d      = ST_C;
              fire      = 1'b1;
              take_lock = 1'b1;
            end
            2'd2: if (st_q == ST_C) begin
              st_d = ST_E;
              fire = 1'b1;
            end
            default: if (st_q == ST_E) begin
              st_d      = ST_I;
              fire      = 1'b1;
              free_lock = 1'b1;
            end
          endcase
        end
      end

      // The wait counter follows the post-edge state. Because of this, a node
      // that leaves Try clears its counter and its starve flag on the same
      // edge.
      always_comb begin
        wait_d = 8'd0;
        if (st_d == ST_T) begin
          wait_d = (wait_q >= WAIT_MAX) ? WAIT_MAX : wait_q + 8'd1;
        end
        starve_d = (wait_d == WAIT_MAX);
      end

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          st_q     <= ST_I;
          wait_q   <= 8'd0;
          starve_q <= 1'b0;
        end else begin
          st_q     <= st_d;
          wait_q   <= wait_d;
          starve_q <= starve_d;
        end
      end

      assign fire_vec[gi]          = fire;
      assign take_vec[gi]          = take_lock;
      assign free_vec[gi]          = free_lock;
      assign crit_next_vec[gi]     = (st_d == ST_C);
      assign starve_vec[gi]        = starve_q;
      assign io_n_state[2*gi +: 2] = st_q;
    end
  endgenerate

  logic fire_any;
  logic multi_crit;

  assign fire_any = |fire_vec;
  // Clearing the lowest set bit leaves a nonzero value exactly when two or
  // more nodes will be in Crit after the edge.
  assign multi_crit = |(crit_next_vec & (crit_next_vec - 1'b1));

  always_comb begin
    x_d = x_q;
    if (|take_vec) begin
      x_d = 1'b0;
    end else if (|free_vec) begin
      x_d = 1'b1;
    end
    fired_d     = fire_any;
    blocked_d   = io_en_valid && !fire_any;
    step_d      = step_q + CNT_W'(fire_any);
    mutex_err_d = mutex_err_q | multi_crit | ((|crit_next_vec) & x_d);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_q         <= 1'b1;
      fired_q     <= 1'b0;
      blocked_q   <= 1'b0;
      mutex_err_q <= 1'b0;
      step_q      <= '0;
    end else begin
      x_q         <= x_d;
      fired_q     <= fired_d;
      blocked_q   <= blocked_d;
      mutex_err_q <= mutex_err_d;
      step_q      <= step_d;
    end
  end

  assign io_x          = x_q;
  assign io_fired      = fired_q;
  assign io_blocked    = blocked_q;
  assign io_starve     = starve_vec;
  assign io_mutex_err  = mutex_err_q;
  assign io_step_count = step_q;

endmodule

// File: tb/tb_mutex_system_n.sv
module tb_mutex_system_n;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_en_valid = 1'b0;
  logic [3:0]  io_en_a = 4'd0;
  logic [5:0]  io_n_state;
  logic        io_x;
  logic        io_fired;
  logic        io_blocked;
  logic [2:0]  io_starve;
  logic        io_mutex_err;
  logic [15:0] io_step_count;

  int errors = 0;
  int checks = 0;

  mutex_system_n #(
    .NUM_NODES(3), .SEL_W(4), .MAX_WAIT(7), .CNT_W(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .io_en_valid(io_en_valid),
    .io_en_a(io_en_a),
    .io_n_state(io_n_state),
    .io_x(io_x),
    .io_fired(io_fired),
    .io_blocked(io_blocked),
    .io_starve(io_starve),
    .io_mutex_err(io_mutex_err),
    .io_step_count(io_step_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        valid;
    logic [3:0]  a;
    logic [5:0]  st;
    logic        x;
    logic        fired;
    logic        blocked;
    logic [2:0]  starve;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [3:0] a, logic [5:0] st, logic x,
                              logic f, logic b, logic [15:0] cnt);
    vec_t r;
    r.valid = v; r.a = a; r.st = st; r.x = x; r.fired = f; r.blocked = b;
    r.starve = 3'd0; r.cnt = cnt;
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(string tag, logic [5:0] st, logic x, logic f, logic b,
                           logic [2:0] starve, logic [15:0] cnt);
    check({tag, ".state"},   32'(io_n_state), 32'(st));
    check({tag, ".x"},       32'(io_x), 32'(x));
    check({tag, ".fired"},   32'(io_fired), 32'(f));
    check({tag, ".blocked"}, 32'(io_blocked), 32'(b));
    check({tag, ".starve"},  32'(io_starve), 32'(starve));
    check({tag, ".err"},     32'(io_mutex_err), 32'd0);
    check({tag, ".cnt"},     32'(io_step_count), 32'(cnt));
  endtask

  // Drive one request, let one rising edge apply it, then sample 1 time unit later
  task automatic step(logic v, logic [3:0] a);
    io_en_valid = v;
    io_en_a     = a;
    @(posedge clock);
    #1;
    $display("step valid=%0d a=%0d -> state=%b x=%0d fired=%0d blocked=%0d starve=%b cnt=%0d",
             v, a, io_n_state, io_x, io_fired, io_blocked, io_starve, io_step_count);
  endtask

  initial begin
    // Table: the state shown is the one after the edge that applied the request.
    // Node k state bits are [2k+1:2k]; T=1, C=2, E=3.
    vecs.push_back(mk(0, 4'd0,  6'd0,  1, 0, 0, 16'd0));   // idle cycle after reset
    vecs.push_back(mk(1, 4'd0,  6'd1,  1, 1, 0, 16'd1));   // n0 Try
    vecs.push_back(mk(1, 4'd1,  6'd2,  0, 1, 0, 16'd2));   // n0 Crit
    vecs.push_back(mk(1, 4'd2,  6'd3,  0, 1, 0, 16'd3));   // n0 Exit
    vecs.push_back(mk(1, 4'd3,  6'd0,  1, 1, 0, 16'd4));   // n0 Idle
    vecs.push_back(mk(1, 4'd0,  6'd1,  1, 1, 0, 16'd5));   // contention: n0 T
    vecs.push_back(mk(1, 4'd4,  6'd5,  1, 1, 0, 16'd6));   // n1 T
    vecs.push_back(mk(1, 4'd1,  6'd6,  0, 1, 0, 16'd7));   // n0 C
    vecs.push_back(mk(1, 4'd5,  6'd6,  0, 0, 1, 16'd7));   // n1 Crit blocked by lock
    vecs.push_back(mk(1, 4'd2,  6'd7,  0, 1, 0, 16'd8));   // n0 E
    vecs.push_back(mk(1, 4'd3,  6'd4,  1, 1, 0, 16'd9));   // n0 I, lock freed
    vecs.push_back(mk(1, 4'd5,  6'd8,  0, 1, 0, 16'd10));  // n1 C
    vecs.push_back(mk(1, 4'd12, 6'd8,  0, 0, 1, 16'd10));  // out of range
    vecs.push_back(mk(1, 4'd15, 6'd8,  0, 0, 1, 16'd10));  // out of range
    vecs.push_back(mk(0, 4'd5,  6'd8,  0, 0, 0, 16'd10));  // not valid
    vecs.push_back(mk(1, 4'd8,  6'd24, 0, 1, 0, 16'd11));  // n2 T
    vecs.push_back(mk(1, 4'd9,  6'd24, 0, 0, 1, 16'd11));  // n2 Crit blocked
    vecs.push_back(mk(1, 4'd6,  6'd28, 0, 1, 0, 16'd12));  // n1 E
    vecs.push_back(mk(1, 4'd7,  6'd16, 1, 1, 0, 16'd13));  // n1 I
    vecs.push_back(mk(1, 4'd9,  6'd32, 0, 1, 0, 16'd14));  // n2 C
    vecs.push_back(mk(1, 4'd10, 6'd48, 0, 1, 0, 16'd15));  // n2 E
    vecs.push_back(mk(1, 4'd11, 6'd0,  1, 1, 0, 16'd16));  // n2 I
    vecs.push_back(mk(1, 4'd2,  6'd0,  1, 0, 1, 16'd16));  // Exit guard false
    vecs.push_back(mk(1, 4'd1,  6'd0,  1, 0, 1, 16'd16));  // Crit guard false from I

    // Reset held low while a request is valid
    io_en_valid = 1'b1;
    io_en_a     = 4'd0;
    repeat (3) @(posedge clock);
    #1;
    check_all("reset", 6'd0, 1, 0, 0, 3'd0, 16'd0);
    #2 reset = 1'b1;   // release away from the clock edge
    step(0, 4'd0);
    check_all("post_reset_idle", 6'd0, 1, 0, 0, 3'd0, 16'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].valid, vecs[i].a);
      check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].x, vecs[i].fired,
                vecs[i].blocked, vecs[i].starve, vecs[i].cnt);
    end

    // Starvation: n1 waits in Try while n0 holds Crit
    step(1, 4'd0);                                 // n0 T
    step(1, 4'd4);                                 // n1 T, wait1=1
    step(1, 4'd1);                                 // n0 C, wait1=2
    check_all("starve_setup", 6'd6, 0, 1, 0, 3'd0, 16'd19);
    repeat (4) step(0, 4'd0);                      // wait1=6
    check("starve_not_yet", 32'(io_starve), 32'd0);
    step(0, 4'd0);                                 // wait1=7
    check("starve_set", 32'(io_starve), 32'b010);
    repeat (2) step(0, 4'd0);                      // saturated
    check("starve_hold", 32'(io_starve), 32'b010);
    step(1, 4'd2);                                 // n0 E
    step(1, 4'd3);                                 // n0 I
    check_all("starve_release", 6'd4, 1, 1, 0, 3'b010, 16'd21);
    step(1, 4'd5);                                 // n1 C clears flag on this edge
    check_all("starve_clear", 6'd8, 0, 1, 0, 3'd0, 16'd22);

    // Async reset mid-cycle with n0 in C and n1 starving
    step(1, 4'd6);                                 // n1 E
    step(1, 4'd7);                                 // n1 I
    step(1, 4'd0);                                 // n0 T
    step(1, 4'd4);                                 // n1 T, wait1=1
    step(1, 4'd1);                                 // n0 C, wait1=2
    repeat (5) step(0, 4'd0);                      // wait1=7
    check_all("pre_async", 6'd6, 0, 0, 0, 3'b010, 16'd27);
    io_en_valid = 1'b1;
    io_en_a     = 4'd0;
    #3 reset = 1'b0;                               // no clock edge in this window
    #1;
    $display("async reset -> state=%b x=%0d starve=%b cnt=%0d",
             io_n_state, io_x, io_starve, io_step_count);
    check_all("async_reset", 6'd0, 1, 0, 0, 3'd0, 16'd0);
    @(posedge clock);
    #1;
    check_all("reset_hold", 6'd0, 1, 0, 0, 3'd0, 16'd0);
    #2 reset = 1'b1;
    step(0, 4'd0);
    check_all("reset_release", 6'd0, 1, 0, 0, 3'd0, 16'd0);
    step(1, 4'd0);
    check_all("after_reset_try", 6'd1, 1, 1, 0, 3'd0, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
